// File: rtl/seq_slot_ctrl.sv
// -----------------------------------------------------------------------------
// seq_slot_ctrl
//
// Slot sequencer for the message/tone address path. A prescaler divides
// sysclk into ticks, DWELL ticks make one slot, NUM_SLOTS slots make one
// pass. The downstream ROM/decoder sees the current slot (addr), the
// position within the pass (count) and a read strobe whenever addr changes.
// A start/stop/pause handshake with busy/done status lets the controlling
// FSM run single or looping passes.
//
// Parameters:
//   CLK_DIV    sysclk cycles per tick (>= 2)
//   DWELL      ticks per slot (>= 1)
//   NUM_SLOTS  slots per pass (1..32, NUM_SLOTS*DWELL <= 256)
//
// Ports:
//   sysclk   in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   start    in   level; begins a pass from IDLE
//   stop     in   level; aborts a running or paused pass
//   pause    in   level; freezes sequencing while high
//   loop_en  in   sampled at end of pass: 1 = wrap, 0 = finish
//   count    out  position in pass, slot*DWELL + dwell
//   addr     out  current slot index
//   rd_en    out  1-cycle strobe, new addr valid
//   tick     out  1-cycle strobe per prescaler tick
//   busy     out  high while RUN or PAUSED
//   done     out  1-cycle strobe on normal pass completion
// -----------------------------------------------------------------------------
module seq_slot_ctrl #(
    parameter int CLK_DIV   = 50000,
    parameter int DWELL     = 13,
    parameter int NUM_SLOTS = 16
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       loop_en,
    output logic [7:0] count,
    output logic [4:0] addr,
    output logic       rd_en,
    output logic       tick,
    output logic       busy,
    output logic       done
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int DW = $clog2(DWELL + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [4:0]    SLOT_LAST  = 5'(NUM_SLOTS - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] PAUSED = 2'd2;

    logic [1:0]    state_reg, state_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [DW-1:0] dwell_reg, dwell_next;
    logic [4:0]    addr_reg,  addr_next;
    logic [7:0]    count_reg, count_next;
    logic          busy_reg,  busy_next;
    logic          rd_en_reg, rd_en_next;
    logic          tick_reg,  tick_next;
    logic          done_reg,  done_next;

    always_comb begin
        state_next = state_reg;
        presc_next = presc_reg;
        dwell_next = dwell_reg;
        addr_next  = addr_reg;
        count_next = count_reg;
        busy_next  = busy_reg;
        rd_en_next = 1'b0;
        tick_next  = 1'b0;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                // stop outranks start; pause alongside start enters PAUSED
                // directly, with the first slot already presented.
                if (start && !stop) begin
                    state_next = pause ? PAUSED : RUN;
                    presc_next = '0;
                    dwell_next = '0;
                    addr_next  = '0;
                    count_next = '0;
                    busy_next  = 1'b1;
                    rd_en_next = 1'b1;
                end
            end

            RUN, PAUSED: begin
                if (stop) begin
                    state_next = IDLE;
                    presc_next = '0;
                    dwell_next = '0;
                    addr_next  = '0;
                    count_next = '0;
                    busy_next  = 1'b0;
                end else if (pause) begin
                    // Everything holds; any tick due on this edge is dropped.
                    state_next = PAUSED;
                end else begin
                    // Leaving PAUSED counts this edge too, so a pause of N
                    // sampled edges delays completion by exactly N cycles.
                    state_next = RUN;
                    if (presc_reg == PRESC_LAST) begin
                        presc_next = '0;
                        tick_next  = 1'b1;
                        if (dwell_reg == DWELL_LAST) begin
                            dwell_next = '0;
                            if (addr_reg == SLOT_LAST) begin
                                addr_next  = '0;
                                count_next = '0;
                                if (loop_en) begin
                                    rd_en_next = 1'b1;
                                end else begin
                                    state_next = IDLE;
                                    busy_next  = 1'b0;
                                    done_next  = 1'b1;
                                end
                            end else begin
                                addr_next  = addr_reg + 5'd1;
                                count_next = count_reg + 8'd1;
                                rd_en_next = 1'b1;
                            end
                        end else begin
                            dwell_next = dwell_reg + DW'(1);
                            count_next = count_reg + 8'd1;
                        end
                    end else begin
                        presc_next = presc_reg + PW'(1);
                    end
                end
            end

            default: begin
                // Unreachable encoding: recover to a clean idle.
                state_next = IDLE;
                presc_next = '0;
                dwell_next = '0;
                addr_next  = '0;
                count_next = '0;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            presc_reg <= '0;
            dwell_reg <= '0;
            addr_reg  <= '0;
            count_reg <= '0;
            busy_reg  <= 1'b0;
            rd_en_reg <= 1'b0;
            tick_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            presc_reg <= presc_next;
            dwell_reg <= dwell_next;
            addr_reg  <= addr_next;
            count_reg <= count_next;
            busy_reg  <= busy_next;
            rd_en_reg <= rd_en_next;
            tick_reg  <= tick_next;
            done_reg  <= done_next;
        end
    end

    assign count = count_reg;
    assign addr  = addr_reg;
    assign rd_en = rd_en_reg;
    assign tick  = tick_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;

endmodule

// File: tb/tb_seq_slot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_slot_ctrl
//
// Directed bench for seq_slot_ctrl with CLK_DIV=4, DWELL=3, NUM_SLOTS=4.
// Each scenario is a table of {cycle after E0, expected outputs} plus a few
// scalar parameters (pause window, loop_en release, stop, re-start). Reset and
// asynchronous reset are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_seq_slot_ctrl;

    logic       sysclk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       pause;
    logic       loop_en;
    logic [7:0] count;
    logic [4:0] addr;
    logic       rd_en;
    logic       tick;
    logic       busy;
    logic       done;

    seq_slot_ctrl #(
        .CLK_DIV   (4),
        .DWELL     (3),
        .NUM_SLOTS (4)
    ) dut (
        .sysclk  (sysclk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .pause   (pause),
        .loop_en (loop_en),
        .count   (count),
        .addr    (addr),
        .rd_en   (rd_en),
        .tick    (tick),
        .busy    (busy),
        .done    (done)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    typedef struct {
        int cyc;
        int count;
        int addr;
        bit rd_en;
        bit tick;
        bit busy;
        bit done;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void add(int c, int cnt, int ad, bit rd, bit tk, bit bs, bit dn);
        vec_t v;
        v.cyc = c; v.count = cnt; v.addr = ad;
        v.rd_en = rd; v.tick = tk; v.busy = bs; v.done = dn;
        vecs.push_back(v);
    endfunction

    task automatic compare(string name, int cyc, vec_t v);
        logic [16:0] act;
        logic [16:0] exp;
        act = {count, addr, rd_en, tick, busy, done};
        exp = {8'(v.count), 5'(v.addr), v.rd_en, v.tick, v.busy, v.done};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got count=%0d addr=%0d rd_en=%b tick=%b busy=%b done=%b want count=%0d addr=%0d rd_en=%b tick=%b busy=%b done=%b",
                     name, cyc, count, addr, rd_en, tick, busy, done,
                     v.count, v.addr, v.rd_en, v.tick, v.busy, v.done);
        end else begin
            $display("ok   %s cyc=%0d count=%0d addr=%0d rd_en=%b tick=%b busy=%b done=%b",
                     name, cyc, count, addr, rd_en, tick, busy, done);
        end
    endtask

    // Starts a pass (E0 = cycle 0), then walks the vector table. Inputs for
    // edge n are set 1 time unit after edge n-1. A parameter of -1 disables it.
    task automatic run(string name, int pause_from, int pause_len, bit loop_init,
                       int loop_off, int stop_at, int restart_at);
        int cyc;
        int n;
        start   = 1'b1;
        loop_en = loop_init;
        @(posedge sysclk); #1;
        cyc   = 0;
        start = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            while (cyc < vecs[i].cyc) begin
                n       = cyc + 1;
                pause   = (pause_from >= 0) && (n >= pause_from) && (n < pause_from + pause_len);
                stop    = (n == stop_at);
                start   = (n == restart_at);
                loop_en = (loop_off >= 0 && n >= loop_off) ? 1'b0 : loop_init;
                @(posedge sysclk); #1;
                cyc++;
            end
            compare(name, cyc, vecs[i]);
        end
        // Return to idle for the next scenario.
        pause = 1'b0; start = 1'b0; loop_en = 1'b0;
        stop  = 1'b1;
        @(posedge sysclk); #1;
        stop  = 1'b0;
        @(posedge sysclk); #1;
        vecs.delete();
    endtask

    initial begin
        vec_t z;
        z.cyc = 0; z.count = 0; z.addr = 0;
        z.rd_en = 0; z.tick = 0; z.busy = 0; z.done = 0;

        reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
        repeat (2) @(posedge sysclk);
        #1;
        compare("reset", 0, z);
        reset = 1'b0;
        repeat (2) @(posedge sysclk);
        #1;
        compare("idle_after_reset", 0, z);

        // Single pass
        add( 0,  0, 0, 1, 0, 1, 0);
        add( 1,  0, 0, 0, 0, 1, 0);
        add( 4,  1, 0, 0, 1, 1, 0);
        add( 5,  1, 0, 0, 0, 1, 0);
        add( 8,  2, 0, 0, 1, 1, 0);
        add(12,  3, 1, 1, 1, 1, 0);
        add(13,  3, 1, 0, 0, 1, 0);
        add(24,  6, 2, 1, 1, 1, 0);
        add(36,  9, 3, 1, 1, 1, 0);
        add(44, 11, 3, 0, 1, 1, 0);
        add(47, 11, 3, 0, 0, 1, 0);
        add(48,  0, 0, 0, 1, 0, 1);
        add(49,  0, 0, 0, 0, 0, 0);
        run("single", -1, 0, 1'b0, -1, -1, -1);

        // Loop, then release loop_en
        add(44, 11, 3, 0, 1, 1, 0);
        add(48,  0, 0, 1, 1, 1, 0);
        add(49,  0, 0, 0, 0, 1, 0);
        add(52,  1, 0, 0, 1, 1, 0);
        add(60,  3, 1, 1, 1, 1, 0);
        add(95, 11, 3, 0, 0, 1, 0);
        add(96,  0, 0, 0, 1, 0, 1);
        add(97,  0, 0, 0, 0, 0, 0);
        run("loop", -1, 0, 1'b1, 60, -1, -1);

        // Pause for 10 edges from E0+5
        add( 4,  1, 0, 0, 1, 1, 0);
        add( 5,  1, 0, 0, 0, 1, 0);
        add(10,  1, 0, 0, 0, 1, 0);
        add(14,  1, 0, 0, 0, 1, 0);
        add(17,  1, 0, 0, 0, 1, 0);
        add(18,  2, 0, 0, 1, 1, 0);
        add(22,  3, 1, 1, 1, 1, 0);
        add(57, 11, 3, 0, 0, 1, 0);
        add(58,  0, 0, 0, 1, 0, 1);
        run("pause", 5, 10, 1'b0, -1, -1, -1);

        // Pause on a tick edge suppresses that tick
        add( 3,  0, 0, 0, 0, 1, 0);
        add( 4,  0, 0, 0, 0, 1, 0);
        add( 5,  1, 0, 0, 1, 1, 0);
        add(48, 11, 3, 0, 0, 1, 0);
        add(49,  0, 0, 0, 1, 0, 1);
        run("pause_on_tick", 4, 1, 1'b0, -1, -1, -1);

        // Stop mid-pass
        add(19,  4, 1, 0, 0, 1, 0);
        add(20,  0, 0, 0, 0, 0, 0);
        add(24,  0, 0, 0, 0, 0, 0);
        add(48,  0, 0, 0, 0, 0, 0);
        run("stop", -1, 0, 1'b0, -1, 20, -1);

        // Stop + pause on a tick edge
        add( 7,  1, 0, 0, 0, 1, 0);
        add( 8,  0, 0, 0, 0, 0, 0);
        add(12,  0, 0, 0, 0, 0, 0);
        run("stop_pause_tick", 8, 1, 1'b0, -1, 8, -1);

        // Start while busy is ignored
        add(10,  2, 0, 0, 0, 1, 0);
        add(11,  2, 0, 0, 0, 1, 0);
        add(12,  3, 1, 1, 1, 1, 0);
        add(47, 11, 3, 0, 0, 1, 0);
        add(48,  0, 0, 0, 1, 0, 1);
        run("start_busy", -1, 0, 1'b0, -1, -1, 10);

        // Asynchronous reset between edges
        begin
            vec_t v;
            start = 1'b1;
            @(posedge sysclk); #1;
            start = 1'b0;
            repeat (6) @(posedge sysclk);
            #1;
            v = z; v.count = 1; v.busy = 1;
            compare("areset_pre", 6, v);
            #2 reset = 1'b1;
            #1;
            compare("areset_immediate", 6, z);
            @(posedge sysclk); #1;
            reset = 1'b0;
            repeat (8) @(posedge sysclk);
            #1;
            compare("areset_stays_idle", 15, z);
            start = 1'b1;
            @(posedge sysclk); #1;
            start = 1'b0;
            v = z; v.rd_en = 1; v.busy = 1;
            compare("areset_restart", 0, v);
            stop = 1'b1;
            @(posedge sysclk); #1;
            stop = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_slot_ctrl.md
# seq_slot_ctrl

Slot sequencer that drives the message/tone address path. It owns the position counter: a prescaled time base advances a dwell counter, and each `DWELL` ticks it steps a slot address. It exposes `count` and `addr` to the downstream ROM/decoder along with a read strobe per slot change. A start/stop/pause handshake with `busy`/`done` status lets the top-level control FSM run single-pass or looping sequences.

## Interface
Parameters:
- `CLK_DIV`, 50000: `sysclk` cycles per tick; must be ≥ 2.
- `DWELL`, 13: ticks per slot; must be ≥ 1.
- `NUM_SLOTS`, 16: slots per pass; must satisfy 1..32 and `NUM_SLOTS*DWELL` ≤ 256.

Ports:
- `sysclk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: level, sampled each edge; begins a pass from IDLE.
- `stop` in 1: level; aborts from RUN/PAUSED.
- `pause` in 1: level; freezes sequencing while high.
- `loop_en` in 1: sampled at end of pass; 1 = wrap, 0 = finish.
- `count` out 8: position in pass, `slot*DWELL + dwell`.
- `addr` out 5: current slot index.
- `rd_en` out 1: 1-cycle strobe, new `addr` valid.
- `tick` out 1: 1-cycle strobe on each prescaler tick.
- `busy` out 1: high in RUN or PAUSED.
- `done` out 1: 1-cycle strobe on normal pass completion.

## Operation
- Reset: state IDLE; `count`, `addr`, `rd_en`, `tick`, `busy`, `done`, prescaler and dwell all 0.
- States: IDLE, RUN, PAUSED. Command priority each edge is `stop` > `pause` > `start`.
- IDLE, `start`=1, `stop`=0:
  - Go to RUN, or to PAUSED if `pause`=1.
  - Prescaler, dwell, slot all set to 0.
  - `busy`=1, `rd_en`=1.
  - `start` while busy is ignored.
- RUN:
  - Prescaler increments each cycle.
  - At the edge where prescaler = `CLK_DIV-1`: prescaler←0, `tick`=1, dwell advances.
  - If dwell was `DWELL-1`: dwell←0, slot advances, `rd_en`=1.
- End of pass: tick with slot = `NUM_SLOTS-1` and dwell = `DWELL-1`.
  - `loop_en`=1: slot←0, dwell←0, `rd_en`=1, stay in RUN.
  - `loop_en`=0: go to IDLE, `done`=1, `busy`=0, `count`/`addr`←0.
- RUN with `pause`=1: go to PAUSED. Prescaler, dwell, slot and outputs hold. No `tick`/`rd_en`.
- PAUSED with `pause`=0: return to RUN; prescaler resumes from its held value.
- `stop` in RUN/PAUSED: go to IDLE, counters and outputs cleared, `done` stays 0. Applies even if the same edge would have ticked or ended the pass.
- `stop` in IDLE: no effect.
- Arithmetic: `count` is registered and unsigned; no wrap occurs within a pass given the parameter constraint.

## Timing
- All outputs are registered; no combinational input→output paths.
- Let E0 be the edge where `start` is accepted. After E0: `busy`=1, `rd_en`=1, `addr`=0, `count`=0.
- Ticks occur at E0+k·`CLK_DIV`, k≥1. `count`/`addr` update on the same edge `tick` rises.
- Completion edge: E0 + `NUM_SLOTS·DWELL·CLK_DIV`, plus total cycles spent in PAUSED.
- `rd_en`, `tick`, `done`: exactly 1 cycle wide, never back-to-back except `tick` when `CLK_DIV` = 2.
- Pause/stop take effect at the edge they are sampled. A tick due on that edge is suppressed.
- `reset` asserted mid-pass: all outputs 0 immediately (asynchronous). Operation restarts only on a new `start` after deassertion.

## Test plan
Parameters for all scenarios: `CLK_DIV`=4, `DWELL`=3, `NUM_SLOTS`=4.
- **Single pass.** `start` pulse at E0, `loop_en`=0.
  - `rd_en` at E0, +12, +24, +36 with `addr` 0, 1, 2, 3.
  - `count` steps 0..11 every 4 cycles.
  - `done`=1 and `busy`=0 at E0+48; `count`=`addr`=0 after.
- **Loop.** Same stimulus with `loop_en`=1.
  - At E0+48: `addr`=0, `rd_en`=1, `busy`=1, no `done`.
  - Clear `loop_en` → `done` at E0+96.
- **Pause.** `pause` high for 10 cycles starting at E0+5.
  - Outputs frozen, no `tick` during the pause.
  - `done` at E0+58.
  - Pause asserted on a tick edge suppresses that tick.
- **Stop.**
  - `stop` at E0+20 → IDLE, all outputs 0, no `done`.
  - `stop`+`pause`+tick on the same edge → IDLE.
- **Start while busy.** `start` re-pulsed at E0+10 → ignored; `done` still at E0+48.
- **Async reset.** `reset` mid-pass between edges → outputs 0 before the next edge. After release, idle until `start`.
